// File: rtl/gpio_bus_pkg.sv
// Shared definitions for the GPIO bus initiator: op/status codes, register map, FSM states.
package gpio_bus_pkg;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_POLL    = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;

  localparam logic [1:0] ADDR_GPI1 = 2'd0;
  localparam logic [1:0] ADDR_GPI2 = 2'd1;
  localparam logic [1:0] ADDR_GPO1 = 2'd2;
  localparam logic [1:0] ADDR_GPO2 = 2'd3;

  typedef enum logic [1:0] {StIdle, StIssue, StGap, StResp} state_e;

endpackage

// File: rtl/gpio_poll_timer.sv
// Gap and attempt counters used to pace and bound poll sequences.
module gpio_poll_timer #(
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned POLL_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic issue_done,
  input  logic gap_active,
  output logic gap_done,
  output logic attempts_exhausted
);

  localparam int unsigned AW = $clog2(POLL_MAX + 1);
  localparam int unsigned GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [GW-1:0] GapLast = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [AW-1:0] AttLast = AW'(POLL_MAX - 1);

  logic [AW-1:0] attempts_q;
  logic [GW-1:0] gap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      attempts_q <= '0;
      gap_q      <= '0;
    end else if (start) begin
      attempts_q <= '0;
      gap_q      <= '0;
    end else if (issue_done) begin
      attempts_q <= attempts_q + 1'b1;
      gap_q      <= '0;
    end else if (gap_active) begin
      gap_q <= gap_q + 1'b1;
    end
  end

  assign gap_done = (gap_q == GapLast);
  // Flags that the read currently being issued is the last one allowed.
  assign attempts_exhausted = (attempts_q == AttLast);

endmodule

// File: rtl/gpio_bus_master.sv
// Bus initiator for the GPIO register map: single reads/writes and poll-until-match.
module gpio_bus_master
  import gpio_bus_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned POLL_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_addr,
  input  logic [WIDTH-1:0] cmd_wdata,
  input  logic [WIDTH-1:0] cmd_mask,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       rsp_status,
  output logic             bus_we,
  output logic [1:0]       bus_a,
  output logic [WIDTH-1:0] bus_wd,
  input  logic [WIDTH-1:0] bus_rd
);

  state_e           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] mask_q;
  logic             gap_done;
  logic             attempts_exhausted;
  logic             poll_match;

  assign cmd_ready  = (state_q == StIdle);
  assign poll_match = ((bus_rd ^ wdata_q) & mask_q) == '0;

  gpio_poll_timer #(
    .POLL_GAP (POLL_GAP),
    .POLL_MAX (POLL_MAX)
  ) u_timer (
    .clk                (clk),
    .rst                (rst),
    .start              (cmd_valid && cmd_ready),
    .issue_done         ((state_q == StIssue) && (op_q == OP_POLL)),
    .gap_active         (state_q == StGap),
    .gap_done           (gap_done),
    .attempts_exhausted (attempts_exhausted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= OP_READ;
      wdata_q    <= '0;
      mask_q     <= '0;
      bus_we     <= 1'b0;
      bus_a      <= '0;
      bus_wd     <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_status <= ST_OK;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            wdata_q <= cmd_wdata;
            mask_q  <= cmd_mask;
            if (cmd_op == OP_ILLEGAL) begin
              // Rejected without touching the bus.
              state_q    <= StResp;
              rsp_valid  <= 1'b1;
              rsp_data   <= '0;
              rsp_status <= ST_ILLEGAL;
            end else begin
              state_q <= StIssue;
              bus_a   <= cmd_addr;
              bus_wd  <= cmd_wdata;
              bus_we  <= (cmd_op == OP_WRITE);
            end
          end
        end
        StIssue: begin
          bus_we <= 1'b0;
          if (op_q == OP_POLL) begin
            rsp_data <= bus_rd;
            if (poll_match) begin
              state_q    <= StResp;
              rsp_valid  <= 1'b1;
              rsp_status <= ST_OK;
            end else if (attempts_exhausted) begin
              state_q    <= StResp;
              rsp_valid  <= 1'b1;
              rsp_status <= ST_TIMEOUT;
            end else if (POLL_GAP == 0) begin
              state_q <= StIssue;
            end else begin
              state_q <= StGap;
            end
          end else begin
            state_q    <= StResp;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_OK;
            rsp_data   <= (op_q == OP_WRITE) ? '0 : bus_rd;
          end
        end
        StGap: begin
          if (gap_done) state_q <= StIssue;
        end
        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_bus_master.sv
// Directed bench for gpio_bus_master with a simple GPIO register responder.
module tb_gpio_bus_master;
  import gpio_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [1:0]  cmd_addr = 2'b00;
  logic [31:0] cmd_wdata = '0;
  logic [31:0] cmd_mask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        bus_we;
  logic [1:0]  bus_a;
  logic [31:0] bus_wd;
  logic [31:0] bus_rd;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] cyc = '0;
  logic [31:0] gpi1 = '0, gpi2 = '0, gpo1 = '0, gpo2 = '0;
  logic        ramp = 1'b0;
  int          we_count = 0;
  logic [31:0] we_cyc = '0, we_data = '0;
  logic [1:0]  we_addr = '0;

  gpio_bus_master #(.WIDTH(32), .POLL_GAP(4), .POLL_MAX(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_mask   (cmd_mask),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_status (rsp_status),
    .bus_we     (bus_we),
    .bus_a      (bus_a),
    .bus_wd     (bus_wd),
    .bus_rd     (bus_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_we) begin
      we_count <= we_count + 1;
      we_cyc   <= cyc;
      we_addr  <= bus_a;
      we_data  <= bus_wd;
      if (bus_a == ADDR_GPO1) gpo1 <= bus_wd;
      if (bus_a == ADDR_GPO2) gpo2 <= bus_wd;
    end
  end

  // In ramp mode GPI1 reads a different value every cycle.
  always_comb begin
    case (bus_a)
      ADDR_GPI1: bus_rd = ramp ? (32'hA000_0000 + cyc) : gpi1;
      ADDR_GPI2: bus_rd = gpi2;
      ADDR_GPO1: bus_rd = gpo1;
      default:   bus_rd = gpo2;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] a, input logic [31:0] wd,
                       input logic [31:0] m, output logic [31:0] t0);
    cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = m; cmd_valid = 1'b1;
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL cmd_ready_before_accept: got %b expected 1", cmd_ready);
    end
    @(posedge clk);
    #1;
    t0 = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output logic [31:0] seen, output logic [31:0] d,
                          output logic [1:0] st);
    seen = '1; d = '0; st = '0;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid === 1'b1) begin
        seen = cyc; d = rsp_data; st = rsp_status;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    tests_run += 7;
    if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    if (bus_we !== 1'b0) begin tests_failed++; $display("FAIL reset_bus_we: got %b expected 0", bus_we); end
    if (bus_a !== 2'd0) begin tests_failed++; $display("FAIL reset_bus_a: got %0d expected 0", bus_a); end
    if (bus_wd !== 32'h0) begin tests_failed++; $display("FAIL reset_bus_wd: got %h expected 0", bus_wd); end
    if (rsp_data !== 32'h0) begin tests_failed++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    if (rsp_status !== 2'b00) begin tests_failed++; $display("FAIL reset_rsp_status: got %b expected 00", rsp_status); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    logic [31:0] t0, seen, d;
    logic [1:0] st;
    we_count = 0;
    issue(OP_WRITE, ADDR_GPO1, 32'hDEAD_BEEF, 32'h0, t0);
    wait_rsp(10, seen, d, st);
    tick(); tick();
    tests_run += 8;
    if (seen !== t0 + 1) begin tests_failed++; $display("FAIL write_latency: got %0d expected %0d", seen, t0 + 1); end
    if (st !== ST_OK) begin tests_failed++; $display("FAIL write_status: got %b expected 00", st); end
    if (d !== 32'h0) begin tests_failed++; $display("FAIL write_data: got %h expected 0", d); end
    if (we_count !== 1) begin tests_failed++; $display("FAIL write_we_cycles: got %0d expected 1", we_count); end
    if (we_cyc !== t0) begin tests_failed++; $display("FAIL write_we_cycle: got %0d expected %0d", we_cyc, t0); end
    if (we_addr !== ADDR_GPO1) begin tests_failed++; $display("FAIL write_bus_a: got %0d expected 2", we_addr); end
    if (we_data !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL write_bus_wd: got %h expected deadbeef", we_data); end
    if (gpo1 !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL write_landed: got %h expected deadbeef", gpo1); end
    issue(OP_READ, ADDR_GPO1, 32'h0, 32'h0, t0);
    wait_rsp(10, seen, d, st);
    tick();
    tests_run += 2;
    if (d !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL readback_data: got %h expected deadbeef", d); end
    if (seen !== t0 + 1) begin tests_failed++; $display("FAIL readback_latency: got %0d expected %0d", seen, t0 + 1); end
  endtask

  task automatic test_read();
    logic [31:0] t0, seen, d;
    logic [1:0] st;
    gpi1 = 32'h1234_5678;
    we_count = 0;
    issue(OP_READ, ADDR_GPI1, 32'h0, 32'h0, t0);
    wait_rsp(10, seen, d, st);
    tick();
    tests_run += 4;
    if (d !== 32'h1234_5678) begin tests_failed++; $display("FAIL read_data: got %h expected 12345678", d); end
    if (st !== ST_OK) begin tests_failed++; $display("FAIL read_status: got %b expected 00", st); end
    if (seen !== t0 + 1) begin tests_failed++; $display("FAIL read_latency: got %0d expected %0d", seen, t0 + 1); end
    if (we_count !== 0) begin tests_failed++; $display("FAIL read_we_cycles: got %0d expected 0", we_count); end
  endtask

  task automatic test_poll_match();
    logic [31:0] t0, seen, d;
    logic [1:0] st;
    gpi2 = 32'h5555_0000;
    we_count = 0;
    issue(OP_POLL, ADDR_GPI2, 32'h1, 32'h1, t0);
    // Reads fall at t0, t0+5, t0+10; raise bit0 between the second and third.
    for (int i = 0; i < 20 && cyc != t0 + 7; i++) tick();
    gpi2 = 32'h5555_0001;
    wait_rsp(20, seen, d, st);
    tick();
    tests_run += 4;
    if (seen !== t0 + 11) begin tests_failed++; $display("FAIL poll_match_latency: got %0d expected %0d", seen, t0 + 11); end
    if (st !== ST_OK) begin tests_failed++; $display("FAIL poll_match_status: got %b expected 00", st); end
    if (d !== 32'h5555_0001) begin tests_failed++; $display("FAIL poll_match_data: got %h expected 55550001", d); end
    if (we_count !== 0) begin tests_failed++; $display("FAIL poll_match_we: got %0d expected 0", we_count); end
    gpi2 = 32'h0000_0F00;
    issue(OP_POLL, ADDR_GPI2, 32'hFFFF_FFFF, 32'h0, t0);
    wait_rsp(20, seen, d, st);
    tick();
    tests_run += 3;
    if (seen !== t0 + 1) begin tests_failed++; $display("FAIL poll_mask0_latency: got %0d expected %0d", seen, t0 + 1); end
    if (st !== ST_OK) begin tests_failed++; $display("FAIL poll_mask0_status: got %b expected 00", st); end
    if (d !== 32'h0000_0F00) begin tests_failed++; $display("FAIL poll_mask0_data: got %h expected 00000f00", d); end
  endtask

  task automatic test_poll_timeout();
    logic [31:0] t0, seen, d;
    logic [1:0] st;
    ramp = 1'b1;
    issue(OP_POLL, ADDR_GPI1, 32'h0, 32'hFFFF_FFFF, t0);
    wait_rsp(120, seen, d, st);
    tick();
    ramp = 1'b0;
    tests_run += 3;
    if (seen !== t0 + 76) begin tests_failed++; $display("FAIL poll_timeout_latency: got %0d expected %0d", seen, t0 + 76); end
    if (st !== ST_TIMEOUT) begin tests_failed++; $display("FAIL poll_timeout_status: got %b expected 01", st); end
    if (d !== 32'hA000_0000 + t0 + 75) begin
      tests_failed++;
      $display("FAIL poll_timeout_data: got %h expected %h", d, 32'hA000_0000 + t0 + 75);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] t0, seen, d;
    logic [1:0] st;
    logic stable;
    we_count = 0;
    rsp_ready = 1'b0;
    issue(OP_ILLEGAL, ADDR_GPO2, 32'hCAFE_F00D, 32'h0, t0);
    wait_rsp(10, seen, d, st);
    tests_run += 3;
    if (seen !== t0) begin tests_failed++; $display("FAIL illegal_latency: got %0d expected %0d", seen, t0); end
    if (st !== ST_ILLEGAL) begin tests_failed++; $display("FAIL illegal_status: got %b expected 10", st); end
    if (d !== 32'h0) begin tests_failed++; $display("FAIL illegal_data: got %h expected 0", d); end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0 || rsp_status !== ST_ILLEGAL || cmd_ready !== 1'b0)
        stable = 1'b0;
    end
    tests_run += 2;
    if (stable !== 1'b1) begin tests_failed++; $display("FAIL illegal_hold_stable: got %b expected 1", stable); end
    if (we_count !== 0) begin tests_failed++; $display("FAIL illegal_we: got %0d expected 0", we_count); end
    rsp_ready = 1'b1;
    tick();
    tests_run += 2;
    if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL illegal_release_valid: got %b expected 0", rsp_valid); end
    if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL illegal_release_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_reset_mid_poll();
    logic [31:0] t0, seen, d;
    logic [1:0] st;
    int spurious;
    gpi2 = 32'h0;
    issue(OP_POLL, ADDR_GPI2, 32'h1, 32'h1, t0);
    tick(); tick();
    rst = 1'b1;
    #1;
    tests_run += 4;
    if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_cmd_ready: got %b expected 1", cmd_ready); end
    if (bus_a !== 2'd0) begin tests_failed++; $display("FAIL midrst_bus_a: got %0d expected 0", bus_a); end
    if (bus_wd !== 32'h0) begin tests_failed++; $display("FAIL midrst_bus_wd: got %h expected 0", bus_wd); end
    if (rsp_data !== 32'h0) begin tests_failed++; $display("FAIL midrst_rsp_data: got %h expected 0", rsp_data); end
    tick(); tick();
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rsp_valid !== 1'b0) spurious++;
    end
    tests_run += 1;
    if (spurious !== 0) begin tests_failed++; $display("FAIL midrst_no_response: got %0d expected 0", spurious); end
    gpi1 = 32'h0BAD_F00D;
    issue(OP_READ, ADDR_GPI1, 32'h0, 32'h0, t0);
    wait_rsp(10, seen, d, st);
    tick();
    tests_run += 2;
    if (d !== 32'h0BAD_F00D) begin tests_failed++; $display("FAIL midrst_read_data: got %h expected 0badf00d", d); end
    if (seen !== t0 + 1) begin tests_failed++; $display("FAIL midrst_read_latency: got %0d expected %0d", seen, t0 + 1); end
  endtask

  initial begin
    #1;
    test_reset();
    test_write();
    test_read();
    test_poll_match();
    test_poll_timeout();
    test_illegal();
    test_reset_mid_poll();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
